// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants
// for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CNT_W  = 6;

    localparam logic [31:0] DIV0_LO = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    typedef enum logic {
        OP_MULT,
        OP_DIV
    } op_t;

endpackage

// File: rtl/muldiv_addsub.sv
// muldiv_addsub: shared add/subtract used by
// both the Booth and restoring iterations.
module muldiv_addsub
    import muldiv_pkg::*;
#(
    parameter int W = DEF_DATA_W + 1
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sub,
    output logic [W-1:0] o_sum
);

    // single adder, b optionally subtracted
    always_comb begin
        o_sum = i_sub ? (i_a - i_b) : (i_a + i_b);
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: signed MULT (Booth r2) and
// DIV (restoring) on one shared adder.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mult_start,
    input  logic              div_start,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              busy,
    output logic              mult_done,
    output logic              div_done,
    output logic              div_zero,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out
);

    localparam int W1 = DATA_W + 1;
    localparam int MS = DATA_W - 1;

    state_t            r_state;
    state_t            w_state_nxt;
    op_t               r_op;
    logic [W1-1:0]     r_acc;
    logic [W1-1:0]     r_m;
    logic [DATA_W-1:0] r_q;
    logic              r_q1;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_dz;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;

    logic              w_mul;
    logic              w_sub;
    logic [W1-1:0]     w_a;
    logic [W1-1:0]     w_sum;
    logic [W1-1:0]     w_booth;
    logic [DATA_W-1:0] w_abs_a;
    logic [W1-1:0]     w_sb;
    logic [W1-1:0]     w_abs_b;
    logic [DATA_W-1:0] w_fix_r;
    logic [DATA_W-1:0] w_fix_q;
    logic              w_b_zero;

    muldiv_addsub #(
        .W(W1)
    ) u_addsub (
        .i_a  (w_a),
        .i_b  (r_m),
        .i_sub(w_sub),
        .o_sum(w_sum)
    );

    // adder operand steering, magnitudes, sign fixup
    always_comb begin
        w_mul    = (r_op == OP_MULT);
        w_a      = w_mul ? r_acc
                         : {r_acc[MS:0], r_q[MS]};
        w_sub    = w_mul ? (r_q[0] & ~r_q1) : 1'b1;
        w_booth  = (r_q[0] ^ r_q1) ? w_sum : r_acc;
        w_abs_a  = op_a[MS] ? (~op_a + 1'b1) : op_a;
        w_sb     = {op_b[MS], op_b};
        w_abs_b  = op_b[MS] ? (~w_sb + 1'b1) : w_sb;
        w_b_zero = (op_b == '0);
        w_fix_r  = r_acc[MS:0];
        w_fix_q  = r_q;
        if (!w_mul && r_neg_r) begin
            w_fix_r = ~r_acc[MS:0] + 1'b1;
        end
        if (!w_mul && r_neg_q) begin
            w_fix_q = ~r_q + 1'b1;
        end
    end

    // next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (mult_start) begin
                    w_state_nxt = S_RUN;
                end else if (div_start) begin
                    w_state_nxt = w_b_zero ? S_DONE
                                           : S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX:   w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // operand latch, iteration and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op    <= OP_MULT;
            r_acc   <= '0;
            r_m     <= '0;
            r_q     <= '0;
            r_q1    <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (mult_start) begin
                        r_op    <= OP_MULT;
                        r_acc   <= '0;
                        r_m     <= {op_a[MS], op_a};
                        r_q     <= op_b;
                        r_q1    <= 1'b0;
                        r_neg_q <= 1'b0;
                        r_neg_r <= 1'b0;
                        r_dz    <= 1'b0;
                        r_cnt   <= CNT_W'(DATA_W);
                    end else if (div_start) begin
                        r_op <= OP_DIV;
                        r_dz <= w_b_zero;
                        if (w_b_zero) begin
                            r_hi <= op_a;
                            r_lo <= DATA_W'(DIV0_LO);
                        end else begin
                            r_acc   <= '0;
                            r_m     <= w_abs_b;
                            r_q     <= w_abs_a;
                            r_neg_q <= op_a[MS] ^ op_b[MS];
                            r_neg_r <= op_a[MS];
                            r_cnt   <= CNT_W'(DATA_W);
                        end
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (w_mul) begin
                        r_acc <= {w_booth[W1-1],
                                  w_booth[W1-1:1]};
                        r_q   <= {w_booth[0], r_q[MS:1]};
                        r_q1  <= r_q[0];
                    end else begin
                        r_acc <= w_sum[W1-1] ? w_a : w_sum;
                        r_q   <= {r_q[MS-1:0],
                                  ~w_sum[W1-1]};
                    end
                end
                S_FIX: begin
                    r_hi <= w_fix_r;
                    r_lo <= w_fix_q;
                end
                S_DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    // status and result outputs
    always_comb begin
        busy      = (r_state != S_IDLE);
        mult_done = (r_state == S_DONE) && (r_op == OP_MULT);
        div_done  = (r_state == S_DONE) && (r_op == OP_DIV);
        div_zero  = div_done && r_dz;
        hi_out    = r_hi;
        lo_out    = r_lo;
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: scoreboard bench with a
// plain-arithmetic reference for MULT/DIV.
module tb_muldiv_sequencer;

    logic        clk;
    logic        reset;
    logic        mult_start;
    logic        div_start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        mult_done;
    logic        div_done;
    logic        div_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    typedef struct {
        bit          is_div;
        bit          dz;
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
    } exp_t;

    exp_t        sbq[$];
    exp_t        e;
    int          cyc;
    int          total;
    int          bad;
    int          n_div_done;
    logic [31:0] last_hi;
    logic [31:0] last_lo;

    muldiv_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .mult_start(mult_start),
        .div_start (div_start),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .mult_done (mult_done),
        .div_done  (div_done),
        .div_zero  (div_zero),
        .hi_out    (hi_out),
        .lo_out    (lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm,
                                logic [63:0] act,
                                logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (cyc %0d)",
                     nm, act, req, cyc);
        end
    endfunction

    // monitor: pop and compare on every done pulse
    always @(negedge clk) begin
        if (!reset) begin
            if (div_done) n_div_done++;
            if (mult_done && div_done) begin
                chk("both_done", 1, 0);
            end else if (mult_done || div_done) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("kind", {63'd0, div_done},
                        {63'd0, e.is_div});
                    chk("div_zero", {63'd0, div_zero},
                        {63'd0, e.dz});
                    chk("hi", {32'd0, hi_out}, {32'd0, e.hi});
                    chk("lo", {32'd0, lo_out}, {32'd0, e.lo});
                    chk("latency", 64'(cyc), 64'(e.due));
                    last_hi = e.hi;
                    last_lo = e.lo;
                end
            end else if (busy) begin
                chk("hold_hi", {32'd0, hi_out},
                    {32'd0, last_hi});
                chk("hold_lo", {32'd0, lo_out},
                    {32'd0, last_lo});
            end
        end
    end

    // reference result for an accepted request
    task automatic push_model(bit m, logic [31:0] a,
                              logic [31:0] b, output int lat);
        exp_t   x;
        longint la;
        longint lb;
        longint p;
        longint q;
        longint r;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        x.is_div = !m;
        x.dz = 0;
        if (m) begin
            p = la * lb;
            x.hi = p[63:32];
            x.lo = p[31:0];
            lat = 34;
        end else if (b == 0) begin
            x.dz = 1;
            x.hi = a;
            x.lo = 32'hFFFFFFFF;
            lat = 1;
        end else begin
            q = la / lb;
            r = la % lb;
            x.hi = r[31:0];
            x.lo = q[31:0];
            lat = 34;
        end
        x.due = cyc + lat;
        sbq.push_back(x);
    endtask

    // one-cycle start; returns in cycle 1 of the op
    task automatic issue(bit m, bit d, logic [31:0] a,
                         logic [31:0] b, output int lat);
        lat = 0;
        if (m || d) push_model(m, a, b, lat);
        mult_start = m;
        div_start  = d;
        op_a = a;
        op_b = b;
        @(posedge clk);
        #1;
        mult_start = 0;
        div_start  = 0;
        op_a = $urandom;
        op_b = $urandom;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    function automatic logic [31:0] rnd_op();
        logic [31:0] c[5];
        c = '{32'h0, 32'h1, 32'hFFFFFFFF,
              32'h80000000, 32'h7FFFFFFF};
        if ($urandom_range(0, 3) == 0) begin
            return c[$urandom_range(0, 4)];
        end
        return $urandom;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int d0;
        int k;
        logic [31:0] a;
        logic [31:0] b;
        cyc = 0;
        total = 0;
        bad = 0;
        n_div_done = 0;
        last_hi = 0;
        last_lo = 0;
        reset = 1;
        mult_start = 0;
        div_start = 0;
        op_a = 32'h12345678;
        op_b = 32'h9ABCDEF0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, busy}, 0);
        chk("rst_mdone", {63'd0, mult_done}, 0);
        chk("rst_ddone", {63'd0, div_done}, 0);
        chk("rst_dzero", {63'd0, div_zero}, 0);
        chk("rst_hi", {32'd0, hi_out}, 0);
        chk("rst_lo", {32'd0, lo_out}, 0);
        reset = 0;
        @(posedge clk);
        #1;

        // 7 * -3 with busy profile
        issue(1, 0, 32'd7, 32'hFFFFFFFD, lat);
        for (k = 1; k <= 34; k++) begin
            chk("busy_run", {63'd0, busy}, 1);
            @(posedge clk);
            #1;
        end
        chk("busy_after", {63'd0, busy}, 0);
        chk("t1_hi", {32'd0, hi_out}, 64'hFFFFFFFF);
        chk("t1_lo", {32'd0, lo_out}, 64'hFFFFFFEB);

        issue(1, 0, 32'h80000000, 32'h80000000, lat);
        wait_idle();
        issue(1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
        wait_idle();
        issue(0, 1, 32'hFFFFFFF9, 32'd2, lat);
        wait_idle();
        issue(0, 1, 32'h80000000, 32'hFFFFFFFF, lat);
        wait_idle();
        chk("ovf_lo", {32'd0, lo_out}, 64'h80000000);
        issue(0, 1, 32'd123, 32'd0, lat);
        wait_idle();

        // simultaneous starts: MULT wins, DIV dropped
        d0 = n_div_done;
        push_model(1, 32'd5, 32'd6, lat);
        mult_start = 1;
        div_start = 1;
        op_a = 32'd5;
        op_b = 32'd6;
        @(posedge clk);
        #1;
        mult_start = 0;
        div_start = 0;
        repeat (8) @(posedge clk);
        #1;
        div_start = 1;
        op_a = 32'd50;
        op_b = 32'd3;
        @(posedge clk);
        #1;
        div_start = 0;
        repeat (40) @(posedge clk);
        #1;
        chk("t5_lo", {32'd0, lo_out}, 64'd30);
        chk("t5_no_div", 64'(n_div_done), 64'(d0));

        // reset in cycle 15 of a MULT
        issue(1, 0, 32'h00001234, 32'h00005678, lat);
        void'(sbq.pop_back());
        repeat (14) @(posedge clk);
        #1;
        reset = 1;
        last_hi = 0;
        last_lo = 0;
        @(posedge clk);
        #1;
        reset = 0;
        chk("mid_rst_busy", {63'd0, busy}, 0);
        chk("mid_rst_hi", {32'd0, hi_out}, 0);
        chk("mid_rst_lo", {32'd0, lo_out}, 0);
        issue(0, 1, 32'd100, 32'd7, lat);
        wait_idle();

        // random ops with ignored starts while busy
        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 5);
            a = rnd_op();
            b = rnd_op();
            if (k == 5) b = 0;
            else if (k >= 3 && b == 0) b = 1;
            issue(k < 3, k >= 3, a, b, lat);
            if ($urandom_range(0, 1) == 1) begin
                d0 = $urandom_range(1, lat);
                repeat (d0 - 1) @(posedge clk);
                #1;
                mult_start = $urandom_range(0, 1);
                div_start = !mult_start;
                op_a = $urandom;
                op_b = $urandom_range(0, 1);
                @(posedge clk);
                #1;
                mult_start = 0;
                div_start = 0;
            end
            wait_idle();
        end

        repeat (5) @(posedge clk);
        #1;
        chk("queue_empty", 64'(sbq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
